// File: rtl/legv8_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : legv8_ctrl_pkg
// Purpose  : Shared encodings for the multicycle LEGv8 control path.
// Revision : 1.0
// ============================================================================
package legv8_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_R_EXEC   = 4'd2,
        S_R_WB     = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_LD_READ  = 4'd5,
        S_LD_WB    = 4'd6,
        S_ST_WRITE = 4'd7,
        S_CBZ      = 4'd8,
        S_BR       = 4'd9
    } state_t;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_LD  = 3'd1,
        CLS_ST  = 3'd2,
        CLS_CBZ = 3'd3,
        CLS_B   = 3'd4,
        CLS_ILL = 3'd5
    } opclass_t;

    localparam logic [10:0] OP_ADD   = 11'b10001011000;
    localparam logic [10:0] OP_SUB   = 11'b11001011000;
    localparam logic [10:0] OP_AND   = 11'b10001010000;
    localparam logic [10:0] OP_ORR   = 11'b10101010000;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    // CBZ and B carry immediate bits inside the opcode field; masks keep only the fixed bits
    localparam logic [10:0] OP_CBZ   = 11'b10110100000;
    localparam logic [10:0] MASK_CBZ = 11'b11111111000;
    localparam logic [10:0] OP_B     = 11'b00010100000;
    localparam logic [10:0] MASK_B   = 11'b11111100000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_DIMM = 2'b10;
    localparam logic [1:0] SRCB_BIMM = 2'b11;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_source;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       fetch;
    } ctrl_t;

    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALUOP_ADD;
                c.fetch     = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_b = SRCB_BIMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = ALUOP_RTYPE;
            end
            S_R_WB:     c.reg_write = 1'b1;
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_DIMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_LD_READ:  c.mem_read = 1'b1;
            S_LD_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_ST_WRITE: c.mem_write = 1'b1;
            S_CBZ: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_REG;
                c.alu_op        = ALUOP_PASSB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 1'b1;
            end
            S_BR: begin
                c.pc_write  = 1'b1;
                c.pc_source = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/legv8_opcode_class.sv
`default_nettype none
// ============================================================================
// Module   : legv8_opcode_class
// Purpose  : Combinational opcode classifier and Reg2Loc select.
// Revision : 1.0
// ============================================================================
module legv8_opcode_class
    import legv8_ctrl_pkg::*;
(
    input  logic [10:0] i_opcode,
    output opclass_t    o_class,
    output logic        o_reg2loc
);

    always_comb begin
        o_class = CLS_ILL;
        if (i_opcode == OP_ADD || i_opcode == OP_SUB ||
            i_opcode == OP_AND || i_opcode == OP_ORR)
            o_class = CLS_R;
        else if (i_opcode == OP_LDUR)
            o_class = CLS_LD;
        else if (i_opcode == OP_STUR)
            o_class = CLS_ST;
        else if ((i_opcode & MASK_CBZ) == OP_CBZ)
            o_class = CLS_CBZ;
        else if ((i_opcode & MASK_B) == OP_B)
            o_class = CLS_B;
    end

    // STUR and CBZ read their second operand from the Rt field
    assign o_reg2loc = (o_class == CLS_ST) || (o_class == CLS_CBZ);

endmodule
`default_nettype wire

// File: rtl/legv8_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : legv8_multicycle_control
// Purpose  : Main control FSM for the multicycle LEGv8 datapath.
//            Optional retired-instruction counter: define RETIRE_CNT_EN.
// Revision : 1.0
// ============================================================================
module legv8_multicycle_control
    import legv8_ctrl_pkg::*;
#(
    parameter logic [3:0] MEM_WAIT_MAX = 4'd15
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [10:0] Opcode,
    input  logic        MemReady,
    output logic [1:0]  ALUop,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        PCSource,
    output logic        IRWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        Reg2Loc,
    output logic        Illegal,
    output logic        MemTimeout
`ifdef RETIRE_CNT_EN
    ,
    output logic [31:0] InstrCount
`endif
);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_wait;
    logic       r_timeout;
    logic       r_illegal;
    opclass_t   w_class;
    ctrl_t      w_ctrl;
    logic       w_mem_state;
    logic       w_next_mem;
    logic       w_expire;
    logic       w_retire;

    legv8_opcode_class u_class (
        .i_opcode  (Opcode),
        .o_class   (w_class),
        .o_reg2loc (Reg2Loc)
    );

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_LD_READ) ||
                         (r_state == S_ST_WRITE);
    assign w_next_mem  = (w_next == S_FETCH) || (w_next == S_LD_READ) ||
                         (w_next == S_ST_WRITE);
    // Expires on the cycle the wait count would reach the limit; a ready in that cycle wins
    assign w_expire    = w_mem_state && !MemReady && (r_wait == MEM_WAIT_MAX - 4'd1);

    always_comb begin
        w_next   = S_FETCH;
        w_retire = 1'b0;
        case (r_state)
            S_FETCH:    w_next = (MemReady && !w_expire) ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (w_class)
                    CLS_R:         w_next = S_R_EXEC;
                    CLS_LD, CLS_ST: w_next = S_MEM_ADDR;
                    CLS_CBZ:       w_next = S_CBZ;
                    CLS_B:         w_next = S_BR;
                    default:       w_next = S_FETCH;
                endcase
            end
            S_R_EXEC:   w_next = S_R_WB;
            S_R_WB:     w_retire = 1'b1;
            S_MEM_ADDR: begin
                if (w_class == CLS_LD)
                    w_next = S_LD_READ;
                else if (w_class == CLS_ST)
                    w_next = S_ST_WRITE;
            end
            S_LD_READ: begin
                if (MemReady)
                    w_next = S_LD_WB;
                else if (!w_expire)
                    w_next = S_LD_READ;
            end
            S_LD_WB:    w_retire = 1'b1;
            S_ST_WRITE: begin
                if (MemReady)
                    w_retire = 1'b1;
                else if (!w_expire)
                    w_next = S_ST_WRITE;
            end
            S_CBZ:      w_retire = 1'b1;
            S_BR:       w_retire = 1'b1;
            default:    w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_timeout <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= (r_state == S_DECODE) && (w_class == CLS_ILL);
            if (w_expire)
                r_timeout <= 1'b1;
            if (w_next_mem && ((w_next != r_state) || w_expire))
                r_wait <= '0;
            else if (w_mem_state && !MemReady)
                r_wait <= r_wait + 4'd1;
        end
    end

`ifdef RETIRE_CNT_EN
    logic [31:0] r_instr_count;

    always_ff @(posedge CLK) begin
        if (Reset)
            r_instr_count <= '0;
        else if (w_retire)
            r_instr_count <= r_instr_count + 32'd1;
    end

    assign InstrCount = r_instr_count;
`else
    logic w_retire_unused;
    assign w_retire_unused = w_retire;
`endif

    assign w_ctrl = ctrl_of(r_state);

    assign ALUop       = w_ctrl.alu_op;
    assign ALUSrcA     = w_ctrl.alu_src_a;
    assign ALUSrcB     = w_ctrl.alu_src_b;
    assign PCSource    = w_ctrl.pc_source;
    assign MemRead     = w_ctrl.mem_read;
    assign MemtoReg    = w_ctrl.mem_to_reg;
    // Write strobes are suppressed while Reset is high so an abandoned instruction commits nothing
    assign PCWrite     = (w_ctrl.pc_write | (w_ctrl.fetch & MemReady)) & ~Reset;
    assign IRWrite     = w_ctrl.fetch & MemReady & ~Reset;
    assign PCWriteCond = w_ctrl.pc_write_cond & ~Reset;
    assign MemWrite    = w_ctrl.mem_write & ~Reset;
    assign RegWrite    = w_ctrl.reg_write & ~Reset;
    assign Illegal     = r_illegal;
    assign MemTimeout  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_legv8_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_legv8_multicycle_control
// Purpose  : Scoreboard bench for the LEGv8 multicycle control FSM.
// Revision : 1.0
// ============================================================================
module tb_legv8_multicycle_control;

    logic        clk;
    logic        Reset;
    logic [10:0] Opcode;
    logic        MemReady;
    logic [1:0]  ALUop;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic        PCWrite, PCWriteCond, PCSource, IRWrite;
    logic        MemRead, MemWrite, MemtoReg, RegWrite;
    logic        Reg2Loc, Illegal, MemTimeout;
`ifdef RETIRE_CNT_EN
    logic [31:0] InstrCount;
`endif

    legv8_multicycle_control #(.MEM_WAIT_MAX(4'd15)) dut (
        .CLK         (clk),
        .Reset       (Reset),
        .Opcode      (Opcode),
        .MemReady    (MemReady),
        .ALUop       (ALUop),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .PCSource    (PCSource),
        .IRWrite     (IRWrite),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .Reg2Loc     (Reg2Loc),
        .Illegal     (Illegal),
        .MemTimeout  (MemTimeout)
`ifdef RETIRE_CNT_EN
        ,
        .InstrCount  (InstrCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bundle: ALUop[15:14] SrcA[13] SrcB[12:11] PCW[10] PCWC[9] PCSrc[8] IRW[7]
    //         MemRd[6] MemWr[5] M2R[4] RegW[3] R2L[2] Ill[1] TO[0]
    logic [15:0] act;
    assign act = {ALUop, ALUSrcA, ALUSrcB, PCWrite, PCWriteCond, PCSource, IRWrite,
                  MemRead, MemWrite, MemtoReg, RegWrite, Reg2Loc, Illegal, MemTimeout};

    localparam logic [15:0] E_FETCH_R = 16'b00_0_01_1_0_0_1_1_0_0_0_000;
    localparam logic [15:0] E_FETCH_W = 16'b00_0_01_0_0_0_0_1_0_0_0_000;
    localparam logic [15:0] E_DECODE  = 16'b00_0_11_0_0_0_0_0_0_0_0_000;
    localparam logic [15:0] E_R_EXEC  = 16'b10_1_00_0_0_0_0_0_0_0_0_000;
    localparam logic [15:0] E_R_WB    = 16'b00_0_00_0_0_0_0_0_0_0_1_000;
    localparam logic [15:0] E_MADDR   = 16'b00_1_10_0_0_0_0_0_0_0_0_000;
    localparam logic [15:0] E_LD_RD   = 16'b00_0_00_0_0_0_0_1_0_0_0_000;
    localparam logic [15:0] E_LD_WB   = 16'b00_0_00_0_0_0_0_0_0_1_1_000;
    localparam logic [15:0] E_ST_WR   = 16'b00_0_00_0_0_0_0_0_1_0_0_000;
    localparam logic [15:0] E_CBZ     = 16'b01_1_00_0_1_1_0_0_0_0_0_000;
    localparam logic [15:0] E_BR      = 16'b00_0_00_1_0_1_0_0_0_0_0_000;
    localparam logic [15:0] R2L = 16'h0004;
    localparam logic [15:0] ILL = 16'h0002;
    localparam logic [15:0] TO  = 16'h0001;

    localparam logic [10:0] O_ADD  = 11'b10001011000;
    localparam logic [10:0] O_LDUR = 11'b11111000010;
    localparam logic [10:0] O_STUR = 11'b11111000000;
    localparam logic [10:0] O_CBZ  = 11'b10110100101;
    localparam logic [10:0] O_B    = 11'b00010111111;
    localparam logic [10:0] O_BAD  = 11'b11111111111;

    typedef struct {
        logic [15:0] exp;
        string       name;
        bit          cchk;
        logic [31:0] cnt;
    } item_t;

    item_t sb[$];
    item_t it;
    int    checks = 0;
    int    errors = 0;

    task automatic step(input logic rst, input logic rdy, input logic [10:0] op,
                        input logic [15:0] exp, input string nm,
                        input bit cchk = 1'b0, input logic [31:0] cnt = 32'd0);
        item_t t;
        Reset    = rst;
        MemReady = rdy;
        Opcode   = op;
        t.exp  = exp;
        t.name = nm;
        t.cchk = cchk;
        t.cnt  = cnt;
        sb.push_back(t);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            it = sb.pop_front();
            checks++;
            if (act !== it.exp) begin
                errors++;
                $display("FAIL %s: outputs got %b expected %b", it.name, act, it.exp);
            end
`ifdef RETIRE_CNT_EN
            if (it.cchk) begin
                checks++;
                if (InstrCount !== it.cnt) begin
                    errors++;
                    $display("FAIL %s_count: InstrCount got %0d expected %0d",
                             it.name, InstrCount, it.cnt);
                end
            end
`endif
        end
    end

    initial begin
        Reset    = 1'b1;
        MemReady = 1'b1;
        Opcode   = O_ADD;
        @(posedge clk);
        #1;
        step(1, 1, O_ADD, E_FETCH_W, "reset", 1'b1, 32'd0);

        // ADD: 4 cycles
        step(0, 1, O_ADD, E_FETCH_R, "add_fetch");
        step(0, 1, O_ADD, E_DECODE,  "add_decode");
        step(0, 1, O_ADD, E_R_EXEC,  "add_exec");
        step(0, 1, O_ADD, E_R_WB,    "add_wb");

        // LDUR with 3 wait cycles in LD_READ: 8 cycles
        step(0, 1, O_LDUR, E_FETCH_R, "ld_fetch");
        step(0, 1, O_LDUR, E_DECODE,  "ld_decode");
        step(0, 1, O_LDUR, E_MADDR,   "ld_addr");
        for (int i = 0; i < 3; i++)
            step(0, 0, O_LDUR, E_LD_RD, "ld_wait");
        step(0, 1, O_LDUR, E_LD_RD,   "ld_ready");
        step(0, 1, O_LDUR, E_LD_WB,   "ld_wb");

        // STUR: 4 cycles, Reg2Loc throughout
        step(0, 1, O_STUR, E_FETCH_R | R2L, "st_fetch");
        step(0, 1, O_STUR, E_DECODE  | R2L, "st_decode");
        step(0, 1, O_STUR, E_MADDR   | R2L, "st_addr");
        step(0, 1, O_STUR, E_ST_WR   | R2L, "st_write");

        // CBZ and B: 3 cycles each
        step(0, 1, O_CBZ, E_FETCH_R | R2L, "cbz_fetch");
        step(0, 1, O_CBZ, E_DECODE  | R2L, "cbz_decode");
        step(0, 1, O_CBZ, E_CBZ     | R2L, "cbz_exec");
        step(0, 1, O_B,   E_FETCH_R, "b_fetch");
        step(0, 1, O_B,   E_DECODE,  "b_decode");
        step(0, 1, O_B,   E_BR,      "b_exec");

        // Illegal opcode, then 15 FETCH cycles without MemReady
        step(0, 1, O_BAD, E_FETCH_R, "ill_fetch");
        step(0, 1, O_BAD, E_DECODE,  "ill_decode");
        step(0, 0, O_BAD, E_FETCH_W | ILL, "ill_pulse");
        for (int i = 1; i < 15; i++)
            step(0, 0, O_BAD, E_FETCH_W, "fetch_wait");
        step(0, 0, O_BAD, E_FETCH_W | TO, "timeout_set");
        step(0, 1, O_LDUR, E_FETCH_R | TO, "timeout_sticky", 1'b1, 32'd5);

        // Reset abandons a load stuck in LD_READ
        step(0, 1, O_LDUR, E_DECODE | TO, "rst_ld_decode");
        step(0, 1, O_LDUR, E_MADDR  | TO, "rst_ld_addr");
        step(0, 0, O_LDUR, E_LD_RD  | TO, "rst_ld_read");
        step(1, 1, O_LDUR, E_LD_RD  | TO, "rst_cycle");
        step(0, 1, O_ADD,  E_FETCH_R, "post_rst_fetch", 1'b1, 32'd0);

        // ADD, STUR, B after reset
        step(0, 1, O_ADD,  E_DECODE, "a2_decode");
        step(0, 1, O_ADD,  E_R_EXEC, "a2_exec");
        step(0, 1, O_ADD,  E_R_WB,   "a2_wb");
        step(0, 1, O_STUR, E_FETCH_R | R2L, "s2_fetch");
        step(0, 1, O_STUR, E_DECODE  | R2L, "s2_decode");
        step(0, 1, O_STUR, E_MADDR   | R2L, "s2_addr");
        step(0, 1, O_STUR, E_ST_WR   | R2L, "s2_write");
        step(0, 1, O_B,    E_FETCH_R, "b2_fetch");
        step(0, 1, O_B,    E_DECODE,  "b2_decode");
        step(0, 1, O_B,    E_BR,      "b2_exec");

        // LDUR where MemReady arrives exactly on the limit cycle
        step(0, 1, O_LDUR, E_FETCH_R, "lim_fetch", 1'b1, 32'd3);
        step(0, 1, O_LDUR, E_DECODE,  "lim_decode");
        step(0, 1, O_LDUR, E_MADDR,   "lim_addr");
        for (int i = 0; i < 14; i++)
            step(0, 0, O_LDUR, E_LD_RD, "lim_wait");
        step(0, 1, O_LDUR, E_LD_RD,   "lim_ready");
        step(0, 1, O_LDUR, E_LD_WB,   "lim_wb");
        step(0, 1, O_ADD,  E_FETCH_R, "lim_done", 1'b1, 32'd4);

        for (int i = 0; i < 10 && sb.size() != 0; i++)
            @(negedge clk);
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/legv8_multicycle_control.md
Name: legv8_multicycle_control

Overview:
Main control FSM for the multicycle LEGv8 datapath.
- Sits directly upstream of the ALU control decoder: drives its 2-bit ALUop, plus every datapath enable and mux select (PC, IR, register file, memory, ALU operand muxes).
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Stalls on a memory-ready handshake.

Parameters:
- MEM_WAIT_MAX, 15, max cycles waited for MemReady in any memory state before flagging MemTimeout (4-bit counter).

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Opcode  input  11  IR[31:21] (valid from DECODE onward).
- MemReady  input  1  memory has completed the current read/write this cycle.
- ALUop  output  2  to ALU control: 00 add, 01 pass-B/CBZ, 10 R-type funct.
- ALUSrcA  output  1  0=PC, 1=register A.
- ALUSrcB  output  2  00=reg B, 01=const 4, 10=sign-ext D-imm, 11=branch-imm<<2.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load if ALU Zero.
- PCSource  output  1  0=ALU result, 1=ALUOut register.
- IRWrite  output  1  load instruction register.
- MemRead  output  1  memory read strobe.
- MemWrite  output  1  memory write strobe.
- MemtoReg  output  1  writeback source: 1=MDR, 0=ALUOut.
- RegWrite  output  1  register file write enable.
- Reg2Loc  output  1  1=read reg2 from Rt (STUR, CBZ).
- Illegal  output  1  one-cycle pulse on unrecognised opcode.
- MemTimeout  output  1  sticky until Reset; wait limit exceeded.

Behaviour:
Outputs and state:
- Moore outputs decoded from a 4-bit state register.
- Reg2Loc is the only combinational output of Opcode.
- Any output not listed for a state is 0.

Reset:
- State=FETCH, wait counter=0, MemTimeout=0.
- Outputs therefore take FETCH values: MemRead=1, ALUSrcB=01, all others 0 (IRWrite/PCWrite follow MemReady).
- Reset mid-instruction abandons it; no writes are issued in the reset cycle.

States:
- FETCH: MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=0. IRWrite=PCWrite=MemReady. Advance to DECODE on MemReady, else hold.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=00 (branch target into ALUOut). Next state by opcode class:
  - R-type (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000) -> R_EXEC.
  - LDUR 11111000010 or STUR 11111000000 -> MEM_ADDR.
  - CBZ 10110100xxx -> CBZ.
  - B 000101xxxxx -> BR.
  - Otherwise -> FETCH with Illegal=1.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUop=10 -> R_WB.
- R_WB: RegWrite=1, MemtoReg=0 -> FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUop=00 -> LD_READ if LDUR, ST_WRITE if STUR.
- LD_READ: MemRead=1; hold until MemReady -> LD_WB.
- LD_WB: RegWrite=1, MemtoReg=1 -> FETCH.
- ST_WRITE: MemWrite=1; hold until MemReady -> FETCH.
- CBZ: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=1 -> FETCH.
- BR: PCWrite=1, PCSource=1 -> FETCH.

Latency (cycles, zero wait): R-type 4, LDUR 5, STUR 4, CBZ 3, B 3.

Memory wait:
- Wait counter clears on entry to FETCH, LD_READ and ST_WRITE, and increments each cycle MemReady=0.
- When it reaches MEM_WAIT_MAX with MemReady still 0: MemTimeout set, state -> FETCH; no IRWrite, PCWrite, RegWrite or MemWrite occurs.
- MemReady in the same cycle as the limit: ready wins.

Unused encodings: unused state encodings (10-15) go to FETCH next cycle with all outputs 0.

Optional Feature:
RETIRE_CNT_EN
- Defined: adds output InstrCount [31:0], reset to 0. It increments by 1 on every transition into FETCH from R_WB, LD_WB, ST_WRITE, CBZ or BR, and wraps at 2^32-1 -> 0. Illegal and timeout exits do not count.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package legv8_ctrl_pkg holds: state encodings; opcode match patterns (with don't-care masks for CBZ/B); ALUop codes 00/01/10; ALUSrcB select codes; opcode class enum {CLS_R, CLS_LD, CLS_ST, CLS_CBZ, CLS_B, CLS_ILL}.
- Sub-module legv8_opcode_class: combinational Opcode -> class and Reg2Loc. It is shared by the FSM and reusable by the ALU control stage.

Test Plan:
- Reset high 2 cycles, MemReady=1, Opcode=ADD -> state sequence FETCH, DECODE, R_EXEC, R_WB, FETCH. ALUop=10 in R_EXEC; RegWrite=1 only in R_WB.
- LDUR with MemReady low 3 cycles in LD_READ -> MemRead held 4 cycles, then LD_WB with MemtoReg=1, RegWrite=1. Total 8 cycles.
- STUR -> Reg2Loc=1. MEM_ADDR drives ALUSrcB=10; ST_WRITE drives MemWrite=1 for exactly the MemReady cycle; RegWrite never asserted.
- CBZ (10110100101) -> CBZ state drives ALUop=01, PCWriteCond=1, PCSource=1. B (00010111111) -> PCWrite=1 in BR; each takes 3 cycles.
- Opcode 11111111111 -> Illegal pulses one cycle at DECODE exit, then FETCH. MemReady held 0 for 15 cycles in FETCH -> MemTimeout=1 sticky, no IRWrite.
- Reset asserted during LD_READ -> next cycle FETCH, RegWrite=0. With RETIRE_CNT_EN, InstrCount=0 and equals 3 after ADD, STUR, B.
